br_resolve_queue: RTL and testbench
===================================

BR_RESOLVE_QUEUE -- requirements
Module: br_resolve_queue

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- NUM_BRQ, 8, number of queue entries; power of 2.
- ROB_W, 5, ROB index width.
- FL_W, 5, free-list index width.
- LSQ_W, 3, SQ/LQ index width.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clock, in, 1, sole clock, rising edge.
- reset, in, 1, synchronous active-low reset.
- alloc_valid, in, 1, dispatch presents a branch.
- alloc_ready, out, 1, entry available.
- alloc_rob_idx, in, ROB_W, branch ROB index.
- alloc_fl_idx, in, FL_W, FL checkpoint index.
- alloc_sq_idx, in, LSQ_W, SQ checkpoint index.
- alloc_lq_idx, in, LSQ_W, LQ checkpoint index.
- alloc_npc, in, 64, PC+4 of the branch.
- alloc_pred_target, in, 64, next PC the front end actually followed.
- alloc_tag, out, log2(NUM_BRQ), entry index granted (equals tail pointer).
- ex_valid, in, 1, execute result valid.
- ex_tag, in, log2(NUM_BRQ), entry being resolved.
- ex_take, in, 1, branch taken.
- ex_target_pc, in, 64, computed taken target.
- out_valid, out, 1, resolved head entry presented to BP.
- out_ready, in, 1, BP accepts.
- out_take_branch, out, 1, resolved direction.
- out_target_pc, out, 64, resolved taken target.
- out_npc, out, 64, branch NPC.
- out_pred_target, out, 64, predicted next PC.
- out_rob_idx, out, ROB_W, checkpoint ROB index.
- out_fl_idx, out, FL_W, checkpoint FL index.
- out_sq_idx, out, LSQ_W, checkpoint SQ index.
- out_lq_idx, out, LSQ_W, checkpoint LQ index.
- rollback_en, in, 1, rollback from BP.
- rollback_rob_idx, in, ROB_W, rollback point.
- rob_tail_idx, in, ROB_W, youngest allocated ROB index, used as age reference.

Function
REQ-003 Circular queue: head pointer, tail pointer, count (0..NUM_BRQ); pointers wrap modulo NUM_BRQ.
REQ-004 Each entry SHALL be in one of FREE, WAIT or RESOLVED.
REQ-005 alloc_ready = (count != NUM_BRQ) && !rollback_en; a pop in the same cycle does not raise alloc_ready.
REQ-006 Allocation fires on alloc_valid && alloc_ready: entry[tail] <= WAIT, fields captured, tail++ and count++ on the next edge.
REQ-007 ex_valid with entry[ex_tag]==WAIT: entry <= RESOLVED; ex_take and ex_target_pc are stored.
REQ-008 ex_valid to a FREE or RESOLVED entry SHALL be ignored.
REQ-009 out_valid = (entry[head]==RESOLVED); out_* are combinational from entry[head]; resolution is reported strictly in program order.
REQ-010 Pop fires on out_valid && out_ready: entry[head] <= FREE, head++, count--.
REQ-011 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-012 Age metric: age(x) = rob_tail_idx - x, computed mod 2^ROB_W; a larger age is older.
REQ-013 On rollback_en, every non-FREE entry with age(entry.rob) < age(rollback_rob_idx) is younger and SHALL become FREE on the next edge.
REQ-014 An entry whose ROB index equals rollback_rob_idx is retained.
REQ-015 Squashed entries form a contiguous suffix. After a squash: tail = position of the oldest squashed entry; count = count minus squashed entries, minus 1 if a pop also fires that cycle.
REQ-016 Simultaneous ex_valid targeting a squashed entry: the squash wins and the entry ends FREE.
REQ-017 Simultaneous pop and rollback: the pop completes if the head entry is not squashed.
REQ-018 rollback_en with count==0 SHALL be a no-op.
REQ-019 Latency: allocate at cycle N, execute at cycle M>N, out_valid at cycle M+1 if the entry is at head.

Reset
REQ-020 When reset==0 at a rising edge: head=tail=0, count=0, all entries FREE.
REQ-021 During reset, out_valid=0 and alloc_ready=0; all out_* data drive 0 while out_valid=0.
REQ-022 Reset asserted mid-operation SHALL discard all entries without emitting any pop.

Verification
REQ-023 Fill: 8 back-to-back allocs with rob 0..7 -> alloc_tag 0..7; alloc_ready=0 after the 8th; a 9th alloc_valid is not accepted.
REQ-024 Out-of-order resolve: ex tag2 then tag0 -> out_valid only after tag0 resolves; pops tag0 (out_rob_idx=0), then stalls until tag1 resolves.
REQ-025 Backpressure: head RESOLVED, out_ready=0 for 3 cycles -> out_* stable, count unchanged; out_ready=1 -> one pop, head=1.
REQ-026 Rollback: entries rob 3..7, rob_tail_idx=7, rollback_rob_idx=5 -> entries rob 6 and 7 freed, tail points to former rob-6 slot, count 5->3.
REQ-027 Wrap and race: entries occupy slots 6,7,0,1; same-cycle ex to slot 1 and rollback squashing slot 1 -> slot 1 FREE, no out_valid for it; next alloc_tag=1.
REQ-028 Reset mid-run: with count=4, drive reset=0 for 1 cycle -> count=0, out_valid=0; next alloc gets alloc_tag=0.

Source files
------------

// File: rtl/br_resolve_queue.sv
// Branch resolve queue: tracks in-flight branches and reports resolved ones to the predictor in program order.
// Latency: a branch resolved at cycle M is presented at cycle M+1 if it is at the head; out_* are combinational from the head.
// Backpressure: the head holds while out_ready=0; alloc_ready drops when the queue is full or a rollback is in progress.
module br_resolve_queue #(
  parameter int NUM_BRQ = 8,
  parameter int ROB_W   = 5,
  parameter int FL_W    = 5,
  parameter int LSQ_W   = 3,
  localparam int TAG_W  = $clog2(NUM_BRQ),
  localparam int CNT_W  = TAG_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [ROB_W-1:0] alloc_rob_idx,
  input  logic [FL_W-1:0]  alloc_fl_idx,
  input  logic [LSQ_W-1:0] alloc_sq_idx,
  input  logic [LSQ_W-1:0] alloc_lq_idx,
  input  logic [63:0]      alloc_npc,
  input  logic [63:0]      alloc_pred_target,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             ex_valid,
  input  logic [TAG_W-1:0] ex_tag,
  input  logic             ex_take,
  input  logic [63:0]      ex_target_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_take_branch,
  output logic [63:0]      out_target_pc,
  output logic [63:0]      out_npc,
  output logic [63:0]      out_pred_target,
  output logic [ROB_W-1:0] out_rob_idx,
  output logic [FL_W-1:0]  out_fl_idx,
  output logic [LSQ_W-1:0] out_sq_idx,
  output logic [LSQ_W-1:0] out_lq_idx,
  input  logic             rollback_en,
  input  logic [ROB_W-1:0] rollback_rob_idx,
  input  logic [ROB_W-1:0] rob_tail_idx
);

  typedef enum logic [1:0] {FREE, WAIT, RESOLVED} ent_state_e;

  typedef struct packed {
    logic [ROB_W-1:0] rob_idx;
    logic [FL_W-1:0]  fl_idx;
    logic [LSQ_W-1:0] sq_idx;
    logic [LSQ_W-1:0] lq_idx;
    logic [63:0]      npc;
    logic [63:0]      pred_target;
    logic             take;
    logic [63:0]      target_pc;
  } ent_t;

  ent_state_e       state_q [NUM_BRQ];
  ent_t             ent_q   [NUM_BRQ];
  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic [NUM_BRQ-1:0] squash;
  logic [CNT_W-1:0]   n_squash;
  logic [ROB_W-1:0]   rb_age;
  logic               alloc_fire;
  logic               pop_fire;

  // Mark every live entry younger than the rollback point; ages are distances back from the ROB tail.
  always_comb begin
    squash   = '0;
    n_squash = '0;
    rb_age   = rob_tail_idx - rollback_rob_idx;
    for (int i = 0; i < NUM_BRQ; i++) begin
      if (rollback_en && (state_q[i] != FREE) &&
          (ROB_W'(rob_tail_idx - ent_q[i].rob_idx) < rb_age)) begin
        squash[i] = 1'b1;
        n_squash  = n_squash + CNT_W'(1);
      end
    end
  end

  // Handshakes and head presentation; data is zeroed whenever nothing valid is at the head.
  always_comb begin
    alloc_ready     = reset && (count_q != CNT_W'(NUM_BRQ)) && !rollback_en;
    alloc_fire      = alloc_valid && alloc_ready;
    alloc_tag       = tail_q;
    out_valid       = reset && (state_q[head_q] == RESOLVED);
    pop_fire        = out_valid && out_ready && !squash[head_q];
    out_take_branch = 1'b0;
    out_target_pc   = '0;
    out_npc         = '0;
    out_pred_target = '0;
    out_rob_idx     = '0;
    out_fl_idx      = '0;
    out_sq_idx      = '0;
    out_lq_idx      = '0;
    if (out_valid) begin
      out_take_branch = ent_q[head_q].take;
      out_target_pc   = ent_q[head_q].target_pc;
      out_npc         = ent_q[head_q].npc;
      out_pred_target = ent_q[head_q].pred_target;
      out_rob_idx     = ent_q[head_q].rob_idx;
      out_fl_idx      = ent_q[head_q].fl_idx;
      out_sq_idx      = ent_q[head_q].sq_idx;
      out_lq_idx      = ent_q[head_q].lq_idx;
    end
  end

  // Pointer/count update; squashed entries are a tail suffix, so the tail simply backs up by their number.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + TAG_W'(pop_fire);
      tail_q  <= tail_q + TAG_W'(alloc_fire) - n_squash[TAG_W-1:0];
      count_q <= count_q + CNT_W'(alloc_fire) - CNT_W'(pop_fire) - n_squash;
    end
  end

  // Per-entry state: squash beats pop, allocation and resolution; resolution only lands on waiting entries.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_BRQ; i++) begin
      if (!reset) begin
        state_q[i] <= FREE;
      end else if (squash[i]) begin
        state_q[i] <= FREE;
      end else if (pop_fire && (head_q == TAG_W'(i))) begin
        state_q[i] <= FREE;
      end else if (alloc_fire && (tail_q == TAG_W'(i))) begin
        state_q[i]           <= WAIT;
        ent_q[i].rob_idx     <= alloc_rob_idx;
        ent_q[i].fl_idx      <= alloc_fl_idx;
        ent_q[i].sq_idx      <= alloc_sq_idx;
        ent_q[i].lq_idx      <= alloc_lq_idx;
        ent_q[i].npc         <= alloc_npc;
        ent_q[i].pred_target <= alloc_pred_target;
        ent_q[i].take        <= 1'b0;
        ent_q[i].target_pc   <= '0;
      end else if (ex_valid && (ex_tag == TAG_W'(i)) && (state_q[i] == WAIT)) begin
        state_q[i]         <= RESOLVED;
        ent_q[i].take      <= ex_take;
        ent_q[i].target_pc <= ex_target_pc;
      end
    end
  end

endmodule

// File: tb/tb_br_resolve_queue.sv
// Bench for br_resolve_queue: table-driven fill plus directed resolve, backpressure, rollback, wrap and reset sequences.
// Expected pops come from a scoreboard queue filled at allocation time, in program order.
// Outputs are sampled 1 time unit after the rising edge or after inputs settle.
module tb_br_resolve_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [4:0]  alloc_rob_idx;
  logic [4:0]  alloc_fl_idx;
  logic [2:0]  alloc_sq_idx;
  logic [2:0]  alloc_lq_idx;
  logic [63:0] alloc_npc;
  logic [63:0] alloc_pred_target;
  logic [2:0]  alloc_tag;
  logic        ex_valid;
  logic [2:0]  ex_tag;
  logic        ex_take;
  logic [63:0] ex_target_pc;
  logic        out_valid;
  logic        out_ready;
  logic        out_take_branch;
  logic [63:0] out_target_pc;
  logic [63:0] out_npc;
  logic [63:0] out_pred_target;
  logic [4:0]  out_rob_idx;
  logic [4:0]  out_fl_idx;
  logic [2:0]  out_sq_idx;
  logic [2:0]  out_lq_idx;
  logic        rollback_en;
  logic [4:0]  rollback_rob_idx;
  logic [4:0]  rob_tail_idx;

  br_resolve_queue dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_rob_idx(alloc_rob_idx), .alloc_fl_idx(alloc_fl_idx),
    .alloc_sq_idx(alloc_sq_idx), .alloc_lq_idx(alloc_lq_idx),
    .alloc_npc(alloc_npc), .alloc_pred_target(alloc_pred_target),
    .alloc_tag(alloc_tag),
    .ex_valid(ex_valid), .ex_tag(ex_tag), .ex_take(ex_take), .ex_target_pc(ex_target_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_take_branch(out_take_branch), .out_target_pc(out_target_pc),
    .out_npc(out_npc), .out_pred_target(out_pred_target),
    .out_rob_idx(out_rob_idx), .out_fl_idx(out_fl_idx),
    .out_sq_idx(out_sq_idx), .out_lq_idx(out_lq_idx),
    .rollback_en(rollback_en), .rollback_rob_idx(rollback_rob_idx),
    .rob_tail_idx(rob_tail_idx)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rob;
    logic [4:0]  fl;
    logic [2:0]  sq;
    logic [2:0]  lq;
    logic [63:0] npc;
    logic [63:0] pred;
    logic        take;
    logic [63:0] target;
    logic [2:0]  tag;
  } rec_t;

  rec_t vec [8];
  rec_t sb [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic rec_t mk(input int rob, input int tag);
    rec_t r;
    r.rob    = 5'(rob);
    r.fl     = 5'(rob + 9);
    r.sq     = 3'(rob);
    r.lq     = 3'(7 - rob);
    r.npc    = 64'h4000_0000 + 64'(rob * 4 + 4);
    r.pred   = (rob % 2 == 1) ? 64'h0000_A000 + 64'(rob * 16) : r.npc;
    r.take   = (rob % 3 == 0);
    r.target = 64'hB000_0000 + 64'(rob * 256);
    r.tag    = 3'(tag);
    return r;
  endfunction

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    sb.delete();
  endtask

  task automatic do_alloc(input string nm, input rec_t r);
    alloc_valid       = 1'b1;
    alloc_rob_idx     = r.rob;
    alloc_fl_idx      = r.fl;
    alloc_sq_idx      = r.sq;
    alloc_lq_idx      = r.lq;
    alloc_npc         = r.npc;
    alloc_pred_target = r.pred;
    #1;
    chk({nm, "_ready"}, 64'(alloc_ready), 64'd1);
    chk({nm, "_tag"}, 64'(alloc_tag), 64'(r.tag));
    sb.push_back(r);
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic resolve(input int tag);
    int idx = -1;
    foreach (sb[k]) if (sb[k].tag == 3'(tag) && idx < 0) idx = k;
    if (idx < 0) begin
      chk("resolve_lookup", 64'(tag), 64'hFFFF);
    end else begin
      ex_valid     = 1'b1;
      ex_tag       = 3'(tag);
      ex_take      = sb[idx].take;
      ex_target_pc = sb[idx].target;
      tick();
      ex_valid = 1'b0;
    end
  endtask

  task automatic cmp_head(input string nm);
    rec_t e;
    e = sb.pop_front();
    chk({nm, "_rob"}, 64'(out_rob_idx), 64'(e.rob));
    chk({nm, "_fl"}, 64'(out_fl_idx), 64'(e.fl));
    chk({nm, "_sq"}, 64'(out_sq_idx), 64'(e.sq));
    chk({nm, "_lq"}, 64'(out_lq_idx), 64'(e.lq));
    chk({nm, "_npc"}, out_npc, e.npc);
    chk({nm, "_pred"}, out_pred_target, e.pred);
    chk({nm, "_take"}, 64'(out_take_branch), 64'(e.take));
    chk({nm, "_target"}, out_target_pc, e.target);
  endtask

  task automatic expect_pop(input string nm);
    int waited = 0;
    out_ready = 1'b1;
    #1;
    while (!out_valid && waited < 20) begin
      tick();
      waited++;
    end
    if (!out_valid) chk({nm, "_timeout"}, 64'(out_valid), 64'd1);
    else if (sb.size() == 0) chk({nm, "_sb_empty"}, 64'd0, 64'd1);
    else cmp_head(nm);
    tick();
    out_ready = 1'b0;
  endtask

  task automatic fill_count(output int n);
    n = 0;
    alloc_valid       = 1'b1;
    alloc_rob_idx     = 5'd0;
    alloc_fl_idx      = 5'd0;
    alloc_sq_idx      = 3'd0;
    alloc_lq_idx      = 3'd0;
    alloc_npc         = 64'h0;
    alloc_pred_target = 64'h0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (alloc_ready) n++;
      tick();
    end
    alloc_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    rec_t r;
    logic [63:0] snap_npc;

    reset = 1'b0; alloc_valid = 1'b0; alloc_rob_idx = '0; alloc_fl_idx = '0;
    alloc_sq_idx = '0; alloc_lq_idx = '0; alloc_npc = '0; alloc_pred_target = '0;
    ex_valid = 1'b0; ex_tag = '0; ex_take = 1'b0; ex_target_pc = '0;
    out_ready = 1'b0; rollback_en = 1'b0; rollback_rob_idx = '0; rob_tail_idx = '0;

    for (int i = 0; i < 8; i++) vec[i] = mk(i, i);

    // Reset state
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd0);
    chk("rst_out_npc", out_npc, 64'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("post_rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("post_rst_tag", 64'(alloc_tag), 64'd0);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Fill from the vector table
    for (int i = 0; i < 8; i++) do_alloc($sformatf("fill%0d", i), vec[i]);
    alloc_valid = 1'b1;
    #1;
    chk("full_alloc_ready", 64'(alloc_ready), 64'd0);
    tick();
    alloc_valid = 1'b0;
    #1;
    chk("full_after_9th", 64'(alloc_ready), 64'd0);

    // Out-of-order resolve; a second ex to a resolved entry is ignored
    resolve(2);
    chk("ooo_no_valid", 64'(out_valid), 64'd0);
    ex_valid = 1'b1; ex_tag = 3'd2; ex_take = ~vec[2].take; ex_target_pc = 64'hDEAD;
    tick();
    ex_valid = 1'b0;
    chk("ooo_still_no_valid", 64'(out_valid), 64'd0);
    resolve(0);
    chk("lat_out_valid", 64'(out_valid), 64'd1);
    chk("lat_rob0", 64'(out_rob_idx), 64'd0);

    // Backpressure
    snap_npc = out_npc;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_npc", out_npc, snap_npc);
      chk("bp_target", out_target_pc, vec[0].target);
      chk("bp_full", 64'(alloc_ready), 64'd0);
    end
    expect_pop("pop0");
    chk("stall_tag1", 64'(out_valid), 64'd0);
    chk("one_pop_ready", 64'(alloc_ready), 64'd1);
    chk("one_pop_tag", 64'(alloc_tag), 64'd0);
    resolve(1);
    expect_pop("pop1");
    expect_pop("pop2");
    for (int t = 3; t < 8; t++) resolve(t);
    for (int t = 3; t < 8; t++) expect_pop($sformatf("pop%0d", t));
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_tag", 64'(alloc_tag), 64'd0);

    // Rollback squashing rob 6 and 7
    pulse_reset();
    for (int i = 0; i < 5; i++) do_alloc($sformatf("rb_alloc%0d", i), mk(i + 3, i));
    rob_tail_idx = 5'd7; rollback_rob_idx = 5'd5; rollback_en = 1'b1;
    #1;
    chk("rb_alloc_blocked", 64'(alloc_ready), 64'd0);
    tick();
    rollback_en = 1'b0;
    void'(sb.pop_back());
    void'(sb.pop_back());
    chk("rb_tail", 64'(alloc_tag), 64'd3);
    fill_count(n);
    chk("rb_count", 64'(n), 64'd5);

    // Reset mid-run with a resolved head and out_ready high
    pulse_reset();
    for (int i = 0; i < 4; i++) do_alloc($sformatf("mr_alloc%0d", i), mk(i, i));
    resolve(0);
    chk("mr_head_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    reset = 1'b0;
    #1;
    chk("mr_rst_valid", 64'(out_valid), 64'd0);
    chk("mr_rst_ready", 64'(alloc_ready), 64'd0);
    chk("mr_rst_npc", out_npc, 64'd0);
    tick();
    reset = 1'b1;
    sb.delete();
    #1;
    chk("mr_post_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    chk("mr_post_tag", 64'(alloc_tag), 64'd0);
    fill_count(n);
    chk("mr_count", 64'(n), 64'd8);

    // Rollback on an empty queue
    pulse_reset();
    rob_tail_idx = 5'd9; rollback_rob_idx = 5'd3; rollback_en = 1'b1;
    tick();
    rollback_en = 1'b0;
    chk("empty_rb_tag", 64'(alloc_tag), 64'd0);
    chk("empty_rb_valid", 64'(out_valid), 64'd0);

    // Wrap to slot 6, then race ex vs rollback on slot 1 with a concurrent pop
    for (int i = 0; i < 6; i++) do_alloc($sformatf("wr_pre%0d", i), mk(i, i));
    for (int i = 0; i < 6; i++) resolve(i);
    for (int i = 0; i < 6; i++) expect_pop($sformatf("wr_prepop%0d", i));
    do_alloc("wr_a6", mk(10, 6));
    do_alloc("wr_a7", mk(11, 7));
    do_alloc("wr_a0", mk(12, 0));
    do_alloc("wr_a1", mk(13, 1));
    resolve(6);
    rob_tail_idx = 5'd13; rollback_rob_idx = 5'd12; rollback_en = 1'b1;
    ex_valid = 1'b1; ex_tag = 3'd1; ex_take = 1'b1; ex_target_pc = 64'hBAD0;
    out_ready = 1'b1;
    #1;
    chk("race_pop_valid", 64'(out_valid), 64'd1);
    cmp_head("race_pop");
    tick();
    rollback_en = 1'b0; ex_valid = 1'b0; out_ready = 1'b0;
    r = sb.pop_back();
    chk("race_tail", 64'(alloc_tag), 64'd1);
    resolve(7);
    resolve(0);
    expect_pop("wr_pop7");
    expect_pop("wr_pop0");
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("race_slot1_silent", 64'(out_valid), 64'd0);
    end
    out_ready = 1'b0;
    chk("race_next_tag", 64'(alloc_tag), 64'd1);
    fill_count(n);
    chk("race_count", 64'(n), 64'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
